// File: rtl/operand_permu_requester.sv
// operand_permu_requester
//
// Read-side initiator for one lane's permutation operand queue. A single read
// command (start VRF row, row count, target FU) is accepted in IDLE, mirrored
// into the queue's command buffer one cycle later, and then expanded into one
// multi-bank VRF row read per cycle. Each read is gated by the queue's
// credit-based ready. Every granted read pulses operand_issued_o so the queue
// can account for its credits.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   flush_i                  abort the current command, return to IDLE
//   req_valid_i/req_ready_o  command handshake
//   req_addr_i               first VRF row
//   req_len_i                number of rows (0 allowed)
//   req_target_fu_i          0 = SLDU, 1 = ADDRGEN
//   vrf_req_o                per-bank read request (all bits equal)
//   vrf_addr_o               row address, stable until granted
//   vrf_gnt_i                read granted on all banks
//   operand_queue_ready_i    queue credit available
//   operand_issued_o         one read granted this cycle
//   opq_cmd_valid_o          push command into the queue (1-cycle pulse)
//   opq_cmd_len_o            row count for the queue
//   opq_cmd_target_fu_o      target FU for the queue
module operand_permu_requester #(
  parameter  int unsigned NrVRFBanksPerLane = 4,
  parameter  int unsigned VLEN              = 4096,
  parameter  int unsigned AddrWidth         = 10,
  localparam int unsigned LenWidth          = $clog2(VLEN + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic [LenWidth-1:0]          req_len_i,
  input  logic                         req_target_fu_i,
  output logic [NrVRFBanksPerLane-1:0] vrf_req_o,
  output logic [AddrWidth-1:0]         vrf_addr_o,
  input  logic                         vrf_gnt_i,
  input  logic                         operand_queue_ready_i,
  output logic                         operand_issued_o,
  output logic                         opq_cmd_valid_o,
  output logic [LenWidth-1:0]          opq_cmd_len_o,
  output logic                         opq_cmd_target_fu_o
);

  typedef enum logic {
    IDLE,
    REQUEST
  } state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [LenWidth-1:0]  remaining_q;
  logic                 opq_cmd_valid_q;
  logic [LenWidth-1:0]  opq_cmd_len_q;
  logic                 opq_cmd_target_fu_q;

  logic in_idle;
  logic in_request;
  logic accept;
  logic read_active;
  logic grant;

  assign in_idle    = (state_q == IDLE);
  assign in_request = (state_q == REQUEST);

  // A flush cycle refuses new commands; acceptance only ever happens in IDLE,
  // which is what creates the single bubble between back-to-back commands.
  assign req_ready_o = in_idle && !flush_i;
  assign accept      = req_ready_o && req_valid_i;

  // The request is only raised while a credit exists, so a grant can never be
  // taken against an empty queue. A grant seen without a credit is ignored.
  assign read_active = in_request && operand_queue_ready_i && !flush_i && !rst_i;
  assign grant       = read_active && vrf_gnt_i;

  assign vrf_req_o        = {NrVRFBanksPerLane{read_active}};
  assign vrf_addr_o       = addr_q;
  assign operand_issued_o = grant;

  assign opq_cmd_valid_o     = opq_cmd_valid_q;
  assign opq_cmd_len_o       = opq_cmd_len_q;
  assign opq_cmd_target_fu_o = opq_cmd_target_fu_q;

  // NOTE: all state is updated with non-blocking assignments in a single
  // clocked block so every register sees the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q             <= IDLE;
      addr_q              <= '0;
      remaining_q         <= '0;
      opq_cmd_valid_q     <= 1'b0;
      opq_cmd_len_q       <= '0;
      opq_cmd_target_fu_q <= 1'b0;
    end else if (flush_i) begin
      state_q         <= IDLE;
      remaining_q     <= '0;
      opq_cmd_valid_q <= 1'b0;
    end else begin
      // Command push into the queue is a single-cycle pulse.
      opq_cmd_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q              <= req_addr_i;
            remaining_q         <= req_len_i;
            opq_cmd_valid_q     <= 1'b1;
            opq_cmd_len_q       <= req_len_i;
            opq_cmd_target_fu_q <= req_target_fu_i;
            // A zero-length command still informs the queue but reads nothing.
            state_q             <= (req_len_i != '0) ? REQUEST : IDLE;
          end
        end
        REQUEST: begin
          if (grant) begin
            // Row address wraps naturally modulo 2^AddrWidth.
            addr_q      <= addr_q + AddrWidth'(1);
            remaining_q <= remaining_q - LenWidth'(1);
            if (remaining_q == LenWidth'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_permu_requester.sv
// Self-checking bench for operand_permu_requester. A behavioural model keeps
// the rows still owed by the current command as a queue of addresses; every
// cycle the DUT outputs are compared against what that queue implies.
module tb_operand_permu_requester;

  localparam int NB    = 4;
  localparam int VLEN  = 4096;
  localparam int AW    = 10;
  localparam int LW    = $clog2(VLEN + 1);
  localparam int AMASK = (1 << AW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i, req_valid_i, req_ready_o, req_target_fu_i;
  logic [AW-1:0] req_addr_i, vrf_addr_o;
  logic [LW-1:0] req_len_i, opq_cmd_len_o;
  logic [NB-1:0] vrf_req_o;
  logic          vrf_gnt_i, operand_queue_ready_i, operand_issued_o;
  logic          opq_cmd_valid_o, opq_cmd_target_fu_o;

  operand_permu_requester #(
    .NrVRFBanksPerLane(NB),
    .VLEN             (VLEN),
    .AddrWidth        (AW)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .flush_i              (flush_i),
    .req_valid_i          (req_valid_i),
    .req_ready_o          (req_ready_o),
    .req_addr_i           (req_addr_i),
    .req_len_i            (req_len_i),
    .req_target_fu_i      (req_target_fu_i),
    .vrf_req_o            (vrf_req_o),
    .vrf_addr_o           (vrf_addr_o),
    .vrf_gnt_i            (vrf_gnt_i),
    .operand_queue_ready_i(operand_queue_ready_i),
    .operand_issued_o     (operand_issued_o),
    .opq_cmd_valid_o      (opq_cmd_valid_o),
    .opq_cmd_len_o        (opq_cmd_len_o),
    .opq_cmd_target_fu_o  (opq_cmd_target_fu_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int issued_cnt = 0;

  // Reference model state.
  int unsigned pend_addr[$];  // rows still to be read, in order
  bit          m_opq_valid;
  int unsigned m_opq_len;
  bit          m_opq_fu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend_addr.delete();
    m_opq_valid = 1'b0;
    m_opq_len   = 0;
    m_opq_fu    = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance model.
  task automatic step(input bit valid, input int unsigned addr, input int unsigned len,
                      input bit fu, input bit gnt, input bit rdy, input bit flush,
                      input bit rst);
    bit busy, exp_rd, exp_iss;
    rst_i = rst; flush_i = flush; req_valid_i = valid;
    req_addr_i = AW'(addr); req_len_i = LW'(len); req_target_fu_i = fu;
    vrf_gnt_i = gnt; operand_queue_ready_i = rdy;
    @(negedge clk_i);
    busy    = (pend_addr.size() != 0);
    exp_rd  = busy && rdy && !flush && !rst;
    exp_iss = exp_rd && gnt;
    check("req_ready", 32'(req_ready_o), 32'(!busy && !flush));
    check("vrf_req", 32'(vrf_req_o), exp_rd ? 32'((1 << NB) - 1) : 32'd0);
    check("issued", 32'(operand_issued_o), 32'(exp_iss));
    if (busy) check("vrf_addr", 32'(vrf_addr_o), pend_addr[0]);
    check("opq_valid", 32'(opq_cmd_valid_o), 32'(m_opq_valid));
    check("opq_len", 32'(opq_cmd_len_o), m_opq_len);
    check("opq_fu", 32'(opq_cmd_target_fu_o), 32'(m_opq_fu));
    if (operand_issued_o) issued_cnt++;
    if (rst) begin
      model_reset();
    end else if (flush) begin
      pend_addr.delete();
      m_opq_valid = 1'b0;
    end else begin
      m_opq_valid = 1'b0;
      if (exp_iss) void'(pend_addr.pop_front());
      if (!busy && valid) begin
        for (int i = 0; i < int'(len); i++) pend_addr.push_back((addr + i) & AMASK);
        m_opq_valid = 1'b1;
        m_opq_len   = len;
        m_opq_fu    = fu;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n, input bit gnt, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, gnt, rdy, 0, 0);
  endtask

  int base;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0;
    req_len_i = '0; req_target_fu_i = 1'b0; vrf_gnt_i = 1'b0;
    operand_queue_ready_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    // Reset held: outputs at reset values, including vrf_addr.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 5, 3, 1, 1, 1, 0, 1);
    check("rst_addr", 32'(vrf_addr_o), 32'd0);
    idle(1, 1, 1);

    // Basic with address wrap.
    base = issued_cnt;
    step(1, 'h3FE, 4, 1, 1, 1, 0, 0);
    idle(6, 1, 1);
    check("basic_issues", issued_cnt - base, 4);

    // Credit stall: no credit for three cycles while granted.
    base = issued_cnt;
    step(1, 'h10, 3, 0, 1, 1, 0, 0);
    idle(1, 1, 1);
    idle(3, 1, 0);
    idle(4, 1, 1);
    check("credit_issues", issued_cnt - base, 3);

    // Grant stall.
    base = issued_cnt;
    step(1, 'h20, 2, 1, 1, 1, 0, 0);
    idle(5, 0, 1);
    idle(3, 1, 1);
    check("gnt_issues", issued_cnt - base, 2);

    // Zero length.
    base = issued_cnt;
    step(1, 'h55, 0, 1, 1, 1, 0, 0);
    idle(2, 1, 1);
    check("zero_issues", issued_cnt - base, 0);

    // Flush after the third issue, with a request presented during the flush.
    base = issued_cnt;
    step(1, 'h100, 8, 0, 1, 1, 0, 0);
    idle(3, 1, 1);
    step(1, 'h200, 2, 1, 1, 1, 1, 0);
    check("flush_issues", issued_cnt - base, 3);
    idle(1, 1, 1);
    base = issued_cnt;
    step(1, 'h300, 1, 1, 1, 1, 0, 0);
    idle(3, 1, 1);
    check("post_flush_issues", issued_cnt - base, 1);

    // Largest legal length.
    base = issued_cnt;
    step(1, 'h7, (1 << LW) - 1, 0, 1, 1, 0, 0);
    idle((1 << LW) + 2, 1, 1);
    check("max_len_issues", issued_cnt - base, (1 << LW) - 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 4, $urandom_range(0, AMASK), $urandom_range(0, 10),
           1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
